mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequencer and arbiter for the single byte-wide, single-port RAM shared by instruction fetch (IF) and the load/store stage (MEM).
- Accepts word fetches from IF and 1/2/4-byte loads/stores from MEM, and grants the RAM to one requester at a time.
- Issues byte accesses in order and assembles little-endian words for reads.
- Returns a completion pulse and data to the requester. Sits between the pipeline stages and the external RAM port.

Parameters:
- RAM_AW, 17, RAM address width; the low RAM_AW bits of the 32-bit request address drive ram_a.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- flush  in  1  branch/jump flush; aborts in-flight IF fetch
- if_req  in  1  IF requests a 4-byte fetch
- if_addr  in  32  fetch PC
- if_addr_needed  out  1  controller idle and able to accept IF address this cycle
- if_done  out  1  one-cycle pulse; if_inst/if_pc valid
- if_inst  out  32  fetched instruction
- if_pc  out  32  PC of the returned instruction
- mem_req  in  1  MEM requests access
- mem_we  in  1  1 = store, 0 = load
- mem_size  in  2  bytes minus one: 0→1, 1→2, 3→4 (value 2 treated as 4)
- mem_addr  in  32  byte address
- mem_wdata  in  32  store data, byte 0 = bits[7:0]
- mem_done  out  1  one-cycle pulse; load data valid / store complete
- mem_rdata  out  32  load data, zero-extended above mem_size
- ram_a  out  RAM_AW  RAM byte address
- ram_wr  out  1  1 = write this cycle
- ram_dout  out  8  write byte
- ram_din  in  8  read byte, valid one cycle after its address

Behaviour:
- Reset (rst_n low, async): state IDLE, byte counter 0. All outputs are 0: if_addr_needed, if_done, if_inst, if_pc, mem_done, mem_rdata, ram_a, ram_wr, ram_dout.
- FSM states: IDLE, IF_RD, MEM_RD, MEM_WR.
- IDLE arbitration at the rising edge:
  - mem_req has priority over if_req.
  - mem_req with mem_we=1 → MEM_WR; mem_req with mem_we=0 → MEM_RD; otherwise if_req → IF_RD.
  - Address, size and write data are latched at the accept edge. Requesters hold their inputs until done, but the controller uses only the latched copies.
- if_addr_needed = 1 only in IDLE with mem_req=0 (combinational).
- Read of n bytes (IF: n=4), cycles c0..cn after the accept edge:
  - In ck (k<n), ram_a = addr+k and ram_wr = 0.
  - In ck (k≥1), ram_din is captured into byte k-1.
  - In cn, ram_a holds addr+n-1 and byte n-1 is captured.
  - Done pulses in cycle c(n+1), together with the return to IDLE. Word reads therefore signal done 6 cycles after the accept edge.
- Write of n bytes:
  - In ck (k<n), ram_a = addr+k, ram_wr = 1, ram_dout = wdata byte k.
  - mem_done pulses in cn, and the FSM is IDLE at cn.
  - ram_wr is 0 in every other cycle.
- Data and done outputs:
  - if_inst, if_pc and mem_rdata are registered and hold their value until the next completion of the same requester.
  - if_pc = latched fetch address.
  - Done pulses last exactly one cycle.
- Back-to-back: a new request may be accepted in the same cycle a done pulse is high. The FSM is in IDLE that cycle.
- Address arithmetic: addr+k wraps modulo 2^RAM_AW.
- Flush:
  - flush=1 in IDLE blocks IF acceptance that cycle.
  - flush=1 during IF_RD → IDLE at the next edge, with no if_done and if_inst/if_pc unchanged.
  - flush is ignored in MEM_RD/MEM_WR; memory side effects are never aborted.
- flush=1 in the cycle if_done is pulsed has no effect on that pulse; IF discards the result.
- Reset mid-transaction: immediate return to the reset state. A partially written store is not rolled back.

Test Plan:
- Reset, then if_req=1, if_addr=0x100, RAM[0x100..0x103]=13,00,00,00 → ram_a sequences 0x100..0x103; if_done pulses at c5 with if_inst=0x00000013 and if_pc=0x100; if_addr_needed=0 during c0..c4.
- if_req and mem_req (load, size=0, addr 0x20, RAM[0x20]=0xFF) asserted together in IDLE → MEM granted first; mem_rdata=0x000000FF at mem_done in c2; IF accepted in the done cycle; if_done follows 6 cycles later.
- Store mem_size=1, addr 0x1FFFF, wdata 0xA1B2C3D4 → ram_wr=1 for exactly 2 cycles with (0x1FFFF,D4) then (0x00000,C3), showing wrap; mem_done pulses in c2.
- IF fetch with flush=1 at c2 → FSM in IDLE at c3; no if_done; if_inst keeps its prior value; the next fetch completes normally.
- rst_n pulled low asynchronously mid-fetch (c2, between edges) → all outputs 0 immediately; after release a fresh fetch returns the correct word.

Source files
------------

// File: rtl/mem_arbiter.sv
// Arbiter/sequencer for a byte-wide single-port RAM shared by instruction fetch and load/store.
// Issues byte accesses in order, assembles little-endian read words, pulses done per requester.
module mem_arbiter #(
    parameter int RAM_AW = 17
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_addr_needed,
    output logic              if_done,
    output logic [31:0]       if_inst,
    output logic [31:0]       if_pc,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [1:0]        mem_size,
    input  logic [31:0]       mem_addr,
    input  logic [31:0]       mem_wdata,
    output logic              mem_done,
    output logic [31:0]       mem_rdata,
    output logic [RAM_AW-1:0] ram_a,
    output logic              ram_wr,
    output logic [7:0]        ram_dout,
    input  logic [7:0]        ram_din
);

    typedef enum logic [1:0] {IDLE, IF_RD, MEM_RD, MEM_WR} state_t;

    // Byte 0 of store data goes straight to ram_dout at accept, so only the upper bytes are kept.
    typedef struct packed {
        logic [31:0] addr;
        logic [23:0] wdata_hi;
        logic [2:0]  len;
    } req_t;

    state_t      state, state_nxt;
    req_t        req;
    logic [2:0]  cnt;
    logic [31:0] rbuf;
    logic [31:0] rd_word;
    logic [7:0]  wr_next;
    logic        rd_last;
    logic        wr_last;

    function automatic logic [2:0] len_of(input logic [1:0] size);
        case (size)
            2'd0:    len_of = 3'd1;
            2'd1:    len_of = 3'd2;
            default: len_of = 3'd4;
        endcase
    endfunction

    assign rd_last        = (cnt == req.len);
    assign wr_last        = (cnt == req.len - 3'd1);
    assign if_addr_needed = rst_n && (state == IDLE) && !mem_req;

    // Byte arriving this cycle belongs to the address issued one cycle earlier.
    always_comb begin
        rd_word = rbuf;
        case (cnt)
            3'd1:    rd_word[7:0]   = ram_din;
            3'd2:    rd_word[15:8]  = ram_din;
            3'd3:    rd_word[23:16] = ram_din;
            3'd4:    rd_word[31:24] = ram_din;
            default: ;
        endcase
    end

    always_comb begin
        case (cnt)
            3'd0:    wr_next = req.wdata_hi[7:0];
            3'd1:    wr_next = req.wdata_hi[15:8];
            default: wr_next = req.wdata_hi[23:16];
        endcase
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (mem_req)
                    state_nxt = mem_we ? MEM_WR : MEM_RD;
                else if (if_req && !flush)
                    state_nxt = IF_RD;
            end
            IF_RD:   if (flush || rd_last) state_nxt = IDLE;
            MEM_RD:  if (rd_last) state_nxt = IDLE;
            MEM_WR:  if (wr_last) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req       <= '0;
            cnt       <= '0;
            rbuf      <= '0;
            if_done   <= 1'b0;
            if_inst   <= '0;
            if_pc     <= '0;
            mem_done  <= 1'b0;
            mem_rdata <= '0;
            ram_a     <= '0;
            ram_wr    <= 1'b0;
            ram_dout  <= '0;
        end else begin
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (mem_req) begin
                        req.addr     <= mem_addr;
                        req.wdata_hi <= mem_wdata[31:8];
                        req.len      <= len_of(mem_size);
                        ram_a        <= mem_addr[RAM_AW-1:0];
                        ram_wr       <= mem_we;
                        ram_dout     <= mem_wdata[7:0];
                        cnt          <= '0;
                        rbuf         <= '0;
                    end else if (if_req && !flush) begin
                        req.addr     <= if_addr;
                        req.wdata_hi <= '0;
                        req.len      <= 3'd4;
                        ram_a        <= if_addr[RAM_AW-1:0];
                        cnt          <= '0;
                        rbuf         <= '0;
                    end
                end
                IF_RD, MEM_RD: begin
                    if (state == IF_RD && flush) begin
                        cnt <= '0;
                    end else if (rd_last) begin
                        cnt <= '0;
                        if (state == IF_RD) begin
                            if_done <= 1'b1;
                            if_inst <= rd_word;
                            if_pc   <= req.addr;
                        end else begin
                            mem_done  <= 1'b1;
                            mem_rdata <= rd_word;
                        end
                    end else begin
                        rbuf <= rd_word;
                        // Last address is held for the final capture cycle.
                        if (cnt + 3'd1 < req.len)
                            ram_a <= ram_a + 1'b1;
                        cnt <= cnt + 3'd1;
                    end
                end
                MEM_WR: begin
                    if (wr_last) begin
                        ram_wr   <= 1'b0;
                        mem_done <= 1'b1;
                        cnt      <= '0;
                    end else begin
                        ram_a    <= ram_a + 1'b1;
                        ram_dout <= wr_next;
                        cnt      <= cnt + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte RAM model returning data one cycle after address.
module tb_mem_arbiter;

    localparam int RAM_AW = 17;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              if_req;
    logic [31:0]       if_addr;
    logic              if_addr_needed;
    logic              if_done;
    logic [31:0]       if_inst;
    logic [31:0]       if_pc;
    logic              mem_req;
    logic              mem_we;
    logic [1:0]        mem_size;
    logic [31:0]       mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_done;
    logic [31:0]       mem_rdata;
    logic [RAM_AW-1:0] ram_a;
    logic              ram_wr;
    logic [7:0]        ram_dout;
    logic [7:0]        ram_din;

    logic [7:0] ram [0:(1<<RAM_AW)-1];

    int n_chk  = 0;
    int n_fail = 0;

    mem_arbiter #(.RAM_AW(RAM_AW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .if_req(if_req), .if_addr(if_addr), .if_addr_needed(if_addr_needed),
        .if_done(if_done), .if_inst(if_inst), .if_pc(if_pc),
        .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ram_a(ram_a), .ram_wr(ram_wr), .ram_dout(ram_dout), .ram_din(ram_din)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        ram_din <= ram[ram_a];
        if (ram_wr)
            ram[ram_a] <= ram_dout;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_need"}, 32'(if_addr_needed), 0);
        chk({tag, "_ifdone"}, 32'(if_done), 0);
        chk({tag, "_inst"}, if_inst, 0);
        chk({tag, "_pc"}, if_pc, 0);
        chk({tag, "_memdone"}, 32'(mem_done), 0);
        chk({tag, "_rdata"}, mem_rdata, 0);
        chk({tag, "_ram_a"}, 32'(ram_a), 0);
        chk({tag, "_ram_wr"}, 32'(ram_wr), 0);
        chk({tag, "_dout"}, 32'(ram_dout), 0);
    endtask

    // Fetch from a held-idle controller; returns at the done cycle (c5).
    task automatic fetch(input logic [31:0] a);
        if_req  = 1'b1;
        if_addr = a;
        cyc();
        if_req = 1'b0;
        repeat (5) cyc();
    endtask

    initial begin
        logic seen;
        for (int i = 0; i < (1 << RAM_AW); i++) ram[i] = 8'h00;
        ram[17'h100] = 8'h13;
        ram[17'h104] = 8'h78; ram[17'h105] = 8'h56;
        ram[17'h106] = 8'h34; ram[17'h107] = 8'h12;
        ram[17'h020] = 8'hFF;

        rst_n = 1'b0; flush = 1'b0; if_req = 1'b0; if_addr = '0;
        mem_req = 1'b0; mem_we = 1'b0; mem_size = '0; mem_addr = '0; mem_wdata = '0;
        cyc(); cyc();
        chk_zero("rst");
        rst_n = 1'b1;

        // Word fetch at 0x100
        if_req = 1'b1; if_addr = 32'h100;
        #1 chk("t1_need_idle", 32'(if_addr_needed), 1);
        cyc();
        if_req = 1'b0;
        for (int k = 0; k < 4; k++) begin
            chk("t1_ram_a", 32'(ram_a), 32'h100 + k);
            chk("t1_ram_wr", 32'(ram_wr), 0);
            chk("t1_need_busy", 32'(if_addr_needed), 0);
            cyc();
        end
        chk("t1_done_c4", 32'(if_done), 0);
        chk("t1_need_c4", 32'(if_addr_needed), 0);
        cyc();
        chk("t1_done_c5", 32'(if_done), 1);
        chk("t1_inst", if_inst, 32'h00000013);
        chk("t1_pc", if_pc, 32'h100);

        // MEM beats IF; IF accepted in the mem_done cycle
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd0; mem_addr = 32'h20;
        if_req = 1'b1; if_addr = 32'h104;
        #1 chk("t2_need_memreq", 32'(if_addr_needed), 0);
        cyc();
        chk("t2_ram_a", 32'(ram_a), 32'h20);
        chk("t2_ifdone_pulse", 32'(if_done), 0);
        cyc();
        chk("t2_memdone_c1", 32'(mem_done), 0);
        cyc();
        chk("t2_memdone_c2", 32'(mem_done), 1);
        chk("t2_rdata", mem_rdata, 32'h000000FF);
        mem_req = 1'b0;
        #1 chk("t2_need_done", 32'(if_addr_needed), 1);
        cyc();
        chk("t2_if_ram_a", 32'(ram_a), 32'h104);
        if_req = 1'b0;
        repeat (4) cyc();
        chk("t2_ifdone_early", 32'(if_done), 0);
        cyc();
        chk("t2_ifdone", 32'(if_done), 1);
        chk("t2_inst", if_inst, 32'h12345678);
        chk("t2_pc", if_pc, 32'h104);
        chk("t2_rdata_hold", mem_rdata, 32'h000000FF);

        // Halfword store wrapping the top of RAM
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd1;
        mem_addr = 32'h1FFFF; mem_wdata = 32'hA1B2C3D4;
        cyc();
        chk("t3_wr_c0", 32'(ram_wr), 1);
        chk("t3_a_c0", 32'(ram_a), 32'h1FFFF);
        chk("t3_dout_c0", 32'(ram_dout), 32'hD4);
        cyc();
        chk("t3_wr_c1", 32'(ram_wr), 1);
        chk("t3_a_c1", 32'(ram_a), 32'h0);
        chk("t3_dout_c1", 32'(ram_dout), 32'hC3);
        cyc();
        chk("t3_wr_c2", 32'(ram_wr), 0);
        chk("t3_done_c2", 32'(mem_done), 1);
        mem_req = 1'b0;
        cyc();
        chk("t3_done_c3", 32'(mem_done), 0);
        chk("t3_ram_top", 32'(ram[17'h1FFFF]), 32'hD4);
        chk("t3_ram_0", 32'(ram[17'h0]), 32'hC3);
        chk("t3_ram_1", 32'(ram[17'h1]), 32'h00);

        // Halfword load back across the wrap, zero-extended
        mem_req = 1'b1; mem_we = 1'b0; mem_size = 2'd1; mem_addr = 32'h1FFFF;
        cyc(); cyc();
        chk("t3b_a_wrap", 32'(ram_a), 32'h0);
        cyc(); cyc();
        chk("t3b_done", 32'(mem_done), 1);
        chk("t3b_rdata", mem_rdata, 32'h0000C3D4);
        // mem_size=2 behaves as a word
        mem_size = 2'd2; mem_addr = 32'h104;
        repeat (5) cyc();
        chk("t3c_done_early", 32'(mem_done), 0);
        cyc();
        chk("t3c_done", 32'(mem_done), 1);
        chk("t3c_rdata", mem_rdata, 32'h12345678);
        mem_req = 1'b0;

        // Flush at c2 aborts the fetch
        if_req = 1'b1; if_addr = 32'h100;
        cyc();
        if_req = 1'b0;
        cyc(); cyc();
        flush = 1'b1;
        cyc();
        chk("t4_idle_c3", 32'(if_addr_needed), 1);
        chk("t4_done_c3", 32'(if_done), 0);
        // Flush in IDLE blocks acceptance
        if_req = 1'b1; if_addr = 32'h200;
        cyc();
        if_req = 1'b0; flush = 1'b0;
        chk("t4_blocked_a", 32'(ram_a), 32'h102);
        seen = 1'b0;
        repeat (7) begin
            cyc();
            if (if_done) seen = 1'b1;
        end
        chk("t4_no_done", 32'(seen), 0);
        chk("t4_inst_hold", if_inst, 32'h12345678);
        chk("t4_pc_hold", if_pc, 32'h104);
        fetch(32'h100);
        chk("t4_refetch_done", 32'(if_done), 1);
        chk("t4_refetch_inst", if_inst, 32'h00000013);
        chk("t4_refetch_pc", if_pc, 32'h100);

        // Async reset mid-fetch
        if_req = 1'b1; if_addr = 32'h104;
        cyc();
        if_req = 1'b0;
        cyc(); cyc();
        #2 rst_n = 1'b0;
        #1 chk_zero("t5_rst");
        cyc();
        rst_n = 1'b1;
        fetch(32'h104);
        chk("t5_done", 32'(if_done), 1);
        chk("t5_inst", if_inst, 32'h12345678);
        chk("t5_pc", if_pc, 32'h104);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
